// File: rtl/cp0_exception_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt/exception arbitration and the
// pipeline-wide flush request, plus mtc0/mfc0 and eret handling.
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2024_0707,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_epc_next;

  // EXL masks both sources, so a held interrupt line cannot re-trigger inside the handler.
  assign w_int_req  = (|(hw_int & r_im)) & r_ie & ~r_exl;
  assign w_exc_req  = (exc_code_in != 5'd0) & ~r_exl;
  assign w_req      = w_int_req | w_exc_req;
  assign w_wr_sr    = en & (cp0_addr == ADDR_SR);
  assign w_wr_epc   = en & (cp0_addr == ADDR_EPC);
  assign w_epc_next = (bd_in ? (vpc - 32'd4) : vpc) & ~32'd3;

  assign req        = w_req;
  assign handler_pc = HANDLER_PC;
  assign epc_out    = r_epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= hw_int;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? 5'd0 : exc_code_in;
        r_bd      <= bd_in;
        r_epc     <= w_epc_next;
      end else begin
        if (eret)
          r_exl <= 1'b0;
        // An SR write alongside eret keeps IM/IE from the data but EXL from the eret.
        if (w_wr_sr) begin
          r_im <= cp0_wdata[15:10];
          r_ie <= cp0_wdata[0];
          if (!eret)
            r_exl <= cp0_wdata[1];
        end
        if (w_wr_epc)
          r_epc <= cp0_wdata;
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
      ADDR_CAUSE: cp0_rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
      ADDR_EPC:   cp0_rdata = r_epc;
      ADDR_PRID:  cp0_rdata = PRID_VALUE;
      default:    cp0_rdata = 32'd0;
    endcase
  end

endmodule
